// File: rtl/cache_access_sequencer_pkg.sv
// cache_seq_pkg: sequencer state encoding and default bus widths
package cache_seq_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_HIT,
    MEM_RD,
    FILL,
    CWRITE,
    MEM_WR,
    RESP
  } state_t;
endpackage

// File: rtl/cache_access_sequencer_if.sv
// cache_access_sequencer_if: requester, cache and memory signals of the sequencer
interface cache_access_sequencer_if import cache_seq_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_hit;
  logic                      c_read_en;
  logic                      c_write_en;
  logic [ADDR_W-1:0]         c_address;
  logic [DATA_W-1:0]         c_write_data;
  logic [DATA_W-1:0]         c_read_data;
  logic                      c_hit;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_ack;
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, c_read_data, c_hit, mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, c_read_en, c_write_en, c_address,
           c_write_data, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, c_read_data, c_hit, mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, c_read_en, c_write_en, c_address,
           c_write_data, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_access_sequencer_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starting after last_grant
module rr_arbiter import cache_seq_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant
);
  logic [GW-1:0] j;
  // walk from farthest to nearest so the requester right after last_grant wins
  always_comb begin
    grant = '0;
    j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req[j]) grant = NUM_REQ'(1) << j;
    end
  end
endmodule

// File: rtl/cache_access_sequencer.sv
// cache_access_sequencer: round-robin front end sequencing lookups, fills and write-through
module cache_access_sequencer import cache_seq_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  cache_access_sequencer_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  state_t state, nxt;
  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0] last_grant, g_q, g_sel;
  logic accept, we_sel, we_q, hit_q, c_rd, c_wr, m_req;
  logic [ADDR_W-1:0] addr_sel, addr_q;
  logic [DATA_W-1:0] wdata_sel, wdata_q, data_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.req_valid),
    .last_grant(last_grant),
    .grant(grant)
  );

  always_comb begin
    g_sel = '0;
    we_sel = 1'b0;
    addr_sel = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        g_sel = GW'(i);
        we_sel = bus.req_we[i];
        addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = bus.req_wdata[i*DATA_W +: DATA_W];
      end
  end

  // ready is withheld while rst is high so nothing looks accepted during reset
  assign accept = state == IDLE && !rst && |grant;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = accept ? (we_sel ? CWRITE : LOOKUP) : IDLE;
      LOOKUP:   nxt = WAIT_HIT;
      WAIT_HIT: nxt = bus.c_hit ? RESP : MEM_RD;
      MEM_RD:   nxt = bus.mem_ack ? FILL : MEM_RD;
      FILL:     nxt = RESP;
      CWRITE:   nxt = MEM_WR;
      MEM_WR:   nxt = bus.mem_ack ? RESP : MEM_WR;
      RESP:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GW'(NUM_REQ - 1);
      g_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      hit_q <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= g_sel;
        g_q <= g_sel;
        we_q <= we_sel;
        addr_q <= addr_sel;
        wdata_q <= wdata_sel;
        hit_q <= 1'b0;
      end
      if (state == WAIT_HIT && bus.c_hit) begin
        data_q <= bus.c_read_data;
        hit_q <= 1'b1;
      end
      if (state == MEM_RD && bus.mem_ack) data_q <= bus.mem_rdata;
    end
  end

  assign c_rd = state == LOOKUP;
  assign c_wr = state == FILL || state == CWRITE;
  assign m_req = state == MEM_RD || state == MEM_WR;

  assign bus.req_ready = accept ? grant : '0;
  assign bus.c_read_en = c_rd;
  assign bus.c_write_en = c_wr;
  assign bus.c_address = (c_rd || c_wr) ? addr_q : '0;
  assign bus.c_write_data = state == FILL ? data_q : state == CWRITE ? wdata_q : '0;
  assign bus.mem_req = m_req;
  assign bus.mem_we = state == MEM_WR;
  assign bus.mem_addr = m_req ? addr_q : '0;
  assign bus.mem_wdata = state == MEM_WR ? wdata_q : '0;
  assign bus.rsp_valid = state == RESP ? NUM_REQ'(1) << g_q : '0;
  assign bus.rsp_rdata = (state == RESP && !we_q) ? data_q : '0;
  assign bus.rsp_hit = state == RESP && hit_q;
endmodule

// File: tb/tb_cache_access_sequencer.sv
// tb_cache_access_sequencer: vector table, corner sequences and random traffic vs a line-level model
module tb_cache_access_sequencer;
  import cache_seq_pkg::*;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_access_sequencer_if #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) bus();
  cache_access_sequencer #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, w_cfg = 0, mcnt = 0, ref_last = N - 1;
  bit stray = 1'b0, env_init = 1'b1;

  function automatic logic [7:0] init_byte(input int i);
    return i == 'h24 ? 8'hA5 : i == 'h04 ? 8'h11 : i == 'h44 ? 8'h22 : 8'(i * 37 + 5);
  endfunction

  // environment: registered-output 4-line cache and a memory acking after w_cfg wait cycles
  logic cv [4];
  logic [5:0] ct [4];
  logic [7:0] cd [4];
  logic [7:0] emem [256];
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 4; i++) cv[i] <= 1'b0;
      for (int i = 0; i < 256; i++) emem[i] <= init_byte(i);
      bus.c_hit <= 1'b0;
      bus.c_read_data <= 8'h00;
    end else begin
      if (bus.c_read_en) begin
        bus.c_hit <= cv[bus.c_address[3:2]] && ct[bus.c_address[3:2]] == bus.c_address[7:2];
        bus.c_read_data <= cd[bus.c_address[3:2]];
      end
      if (bus.c_write_en) begin
        cv[bus.c_address[3:2]] <= 1'b1;
        ct[bus.c_address[3:2]] <= bus.c_address[7:2];
        cd[bus.c_address[3:2]] <= bus.c_write_data;
      end
      if (bus.mem_req && bus.mem_ack && bus.mem_we) emem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  always @(posedge clk or posedge rst)
    if (rst) mcnt <= 0;
    else if (bus.mem_req) mcnt <= bus.mem_ack ? 0 : mcnt + 1;
  assign bus.mem_ack = (bus.mem_req && mcnt == w_cfg) || stray;
  assign bus.mem_rdata = emem[bus.mem_addr];

  // reference: coherent memory plus which line holds which tag
  logic [7:0] rmem [256];
  bit rv [4];
  logic [5:0] rt [4];
  logic [7:0] rdat [4];
  function automatic void predict(input bit we, input logic [7:0] a, input logic [7:0] d, input int w,
                                  output logic [7:0] rd, output bit h, output int lat);
    int x = int'(a[3:2]);
    h = !we && rv[x] && rt[x] == a[7:2];
    if (we) begin rmem[a] = d; rd = 8'h00; lat = 3 + w; end
    else if (h) begin rd = rdat[x]; lat = 3; end
    else begin rd = rmem[a]; lat = 5 + w; end
    if (!h) begin rv[x] = 1'b1; rt[x] = a[7:2]; rdat[x] = we ? d : rd; end
  endfunction

  function automatic int rr_next(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm, input int r, input bit we, input logic [7:0] a, input logic [7:0] d,
                     input int w, input logic [7:0] erd, input bit eh, input int elat);
    int n = 0, lat = 0, who = -1, nrd = 0, nwr = 0, nmem = 0, bad = 0;
    logic [7:0] rd = 8'h00;
    bit h = 1'b0;
    @(posedge clk); #1;
    w_cfg = w;
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_we[r] = we;
    bus.req_addr[r*8 +: 8] = a;
    bus.req_wdata[r*8 +: 8] = d;
    @(negedge clk);
    while (!bus.req_ready[r] && n < 20) begin @(negedge clk); n++; end
    chk({nm, " accept"}, 32'(bus.req_ready), 32'(N'(1) << r));
    @(posedge clk); #1;
    bus.req_valid = '0;
    ref_last = r;
    while (who < 0 && lat < 60) begin
      @(negedge clk);
      lat++;
      nrd += int'(bus.c_read_en);
      nwr += int'(bus.c_write_en);
      if (bus.c_read_en && bus.c_write_en) bad++;
      if (bus.mem_req ? (bus.mem_addr !== a || bus.mem_we !== we || bus.mem_wdata !== (we ? d : 8'h00))
                      : (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00)) bad++;
      if (bus.mem_req) nmem++;
      if (bus.rsp_valid != 0) begin
        for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) who = i;
        if ($countones(bus.rsp_valid) != 1) bad++;
        rd = bus.rsp_rdata;
        h = bus.rsp_hit;
      end
    end
    @(negedge clk);
    chk({nm, " rsp_pulse"}, 32'(bus.rsp_valid), 0);
    chk({nm, " who"}, who, r);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " rdata"}, 32'(rd), 32'(erd));
    chk({nm, " hit"}, 32'(h), 32'(eh));
    chk({nm, " c_read_cycles"}, nrd, we ? 0 : 1);
    chk({nm, " c_write_cycles"}, nwr, (we || !eh) ? 1 : 0);
    chk({nm, " mem_cycles"}, nmem, eh ? 0 : w + 1);
    chk({nm, " bus_rules"}, bad, 0);
  endtask

  task automatic model_run(input string nm, input int r, input bit we, input logic [7:0] a,
                           input logic [7:0] d, input int w);
    logic [7:0] erd;
    bit eh;
    int el;
    predict(we, a, d, w, erd, eh, el);
    run(nm, r, we, a, d, w, erd, eh, el);
  endtask

  // hold several requesters valid; expect rr order and back-to-back accepts
  task automatic stream(input string nm, input logic [N-1:0] m, input logic [8*N-1:0] addrs, input int cnt);
    int ew [8], el [8];
    logic [7:0] erd [8];
    bit eh [8];
    int acc = 0, nr = 0, cyc = 0, last = 0, two = 0, who = -1;
    for (int k = 0; k < cnt; k++) begin
      ew[k] = rr_next(m, ref_last);
      ref_last = ew[k];
      predict(1'b0, addrs[ew[k]*8 +: 8], 8'h00, 0, erd[k], eh[k], el[k]);
    end
    @(posedge clk); #1;
    w_cfg = 0;
    bus.req_we = '0;
    bus.req_addr = addrs;
    bus.req_valid = m;
    while (nr < cnt && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if ($countones(bus.req_ready) > 1) two++;
      if (bus.req_ready != 0) acc++;
      if (bus.rsp_valid != 0) begin
        for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) who = i;
        chk($sformatf("%s who%0d", nm, nr), who, ew[nr]);
        chk($sformatf("%s rdata%0d", nm, nr), 32'(bus.rsp_rdata), 32'(erd[nr]));
        chk($sformatf("%s hit%0d", nm, nr), 32'(bus.rsp_hit), 32'(eh[nr]));
        if (nr > 0) chk($sformatf("%s spacing%0d", nm, nr), cyc - last, 1 + el[nr]);
        last = cyc;
        nr++;
      end
      if (acc == cnt && bus.req_valid != 0) begin @(posedge clk); #1; bus.req_valid = '0; end
    end
    bus.req_valid = '0;
    chk({nm, " responses"}, nr, cnt);
    chk({nm, " ready_two_hot"}, two, 0);
  endtask

  typedef struct {
    int r; bit we; logic [7:0] a; logic [7:0] d; int w;
    logic [7:0] rd; bit h; int lat;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int n, bad;
    logic [7:0] ra, rdd;
    bit rwe;
    tbl[0]  = '{0, 1'b0, 8'h24, 8'h00, 2, 8'hA5, 1'b0, 7};
    tbl[1]  = '{0, 1'b0, 8'h24, 8'h00, 0, 8'hA5, 1'b1, 3};
    tbl[2]  = '{1, 1'b1, 8'h10, 8'h3C, 1, 8'h00, 1'b0, 4};
    tbl[3]  = '{0, 1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b1, 3};
    tbl[4]  = '{0, 1'b0, 8'h04, 8'h00, 0, 8'h11, 1'b0, 5};
    tbl[5]  = '{1, 1'b0, 8'h44, 8'h00, 3, 8'h22, 1'b0, 8};
    tbl[6]  = '{0, 1'b0, 8'h04, 8'h00, 1, 8'h11, 1'b0, 6};
    tbl[7]  = '{1, 1'b0, 8'h04, 8'h00, 0, 8'h11, 1'b1, 3};
    tbl[8]  = '{1, 1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b1, 3};
    tbl[9]  = '{0, 1'b1, 8'h14, 8'h5A, 0, 8'h00, 1'b0, 3};
    tbl[10] = '{1, 1'b0, 8'h04, 8'h00, 0, 8'h11, 1'b0, 5};
    tbl[11] = '{0, 1'b0, 8'h14, 8'h00, 2, 8'h5A, 1'b0, 7};
    tbl[12] = '{0, 1'b0, 8'h24, 8'h00, 0, 8'hA5, 1'b0, 5};
    for (int i = 0; i < 256; i++) rmem[i] = init_byte(i);
    for (int i = 0; i < 4; i++) rv[i] = 1'b0;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 bus.req_valid = '1;
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 0);
    chk("reset rsp", {bus.rsp_valid, bus.rsp_hit, bus.rsp_rdata}, 0);
    chk("reset mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("reset cache", {bus.c_read_en, bus.c_write_en, bus.c_address, bus.c_write_data}, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    env_init = 1'b0;

    for (int i = 0; i < 13; i++) begin
      logic [7:0] prd;
      bit ph;
      int pl;
      predict(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].w, prd, ph, pl);
      run($sformatf("vec%0d", i), tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].rd, tbl[i].h, tbl[i].lat);
    end

    @(posedge clk); #1 stray = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid != 0 || bus.mem_req || bus.c_read_en || bus.c_write_en) bad++;
    end
    chk("stray ack idle", bad, 0);
    model_run("stray_wr", 1, 1'b1, 8'h20, 8'h77, 0);
    bad = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid != 0 || bus.mem_req) bad++; end
    chk("stray ack after", bad, 0);
    stray = 1'b0;

    stream("fair", 2'b11, {8'h44, 8'h24}, 6);
    stream("b2b", 2'b10, {8'h44, 8'h24}, 3);

    @(posedge clk); #1;
    w_cfg = 50;
    bus.req_we = '0;
    bus.req_addr = {8'h24, 8'h80};
    bus.req_valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!bus.mem_req && n < 10) begin @(negedge clk); n++; end
    chk("abort mem_req before", 32'(bus.mem_req), 1);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    #1;
    chk("abort mem_req", 32'(bus.mem_req), 0);
    chk("abort req_ready", 32'(bus.req_ready), 0);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_last = N - 1;
    #1;
    chk("post reset grant", 32'(bus.req_ready), 32'(N'(1) << rr_next(2'b11, ref_last)));
    bus.req_valid = '0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (bus.rsp_valid != 0 || bus.mem_req) bad++; end
    chk("abort no response", bad, 0);
    model_run("post_reset_r1", 1, 1'b0, 8'h80, 8'h00, 1);

    for (int i = 0; i < 40; i++) begin
      rwe = $urandom_range(0, 3) == 0;
      ra = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      rdd = 8'($urandom);
      model_run($sformatf("rand%0d", i), $urandom_range(0, 1), rwe, ra, rdd, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
